rr_arb_mux: RTL and testbench

- Parametrised successor of the 2:1 combinational mux: N_CH-input, WIDTH-bit registered multiplexer with round-robin select.
- Selection is driven by per-channel valid/ready handshakes instead of an external sel.
- Sits between several producer streams and one consumer stream: merges channels and tags each output word with its source channel.
- One output register stage; full throughput of one word per cycle.

---
 rtl/rr_arb_mux_if.sv | 31 +++
 rtl/rr_arb_mux.sv | 95 +++++++++
 tb/tb_rr_arb_mux.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb_mux_if.sv
`default_nettype none
//============================================================================
// Module   : rr_arb_mux_if
// Purpose  : Stream bundle between N_CH producers, the arbiter and one consumer.
// Revision : 1.0
//============================================================================
interface rr_arb_mux_if #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic [N_CH*WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic [CH_W-1:0]       out_ch;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
//============================================================================
// Module   : rr_arb_mux
// Purpose  : N_CH-input registered mux with round-robin valid/ready arbitration;
//            RR_ARB_MUX_FIXED_PRIO_EN selects strict lowest-index priority.
// Revision : 1.0
//============================================================================
module rr_arb_mux #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8
) (
   input  wire logic    clk,
   input  wire logic    rst,
   rr_arb_mux_if.slave  bus
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [CH_W-1:0]  w_start;
   logic             w_found;
   logic [CH_W-1:0]  w_winner;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_slot_free;
   logic             w_xfer;
   logic [N_CH-1:0]  w_in_ready;

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [CH_W-1:0]  r_ch;

   assign w_slot_free = !r_valid || bus.out_ready;
   assign w_xfer      = w_slot_free && w_found;

   // Circular search starting at w_start; the first valid channel wins.
   always_comb begin
      int idx;
      idx        = 0;
      w_found    = 1'b0;
      w_winner   = '0;
      w_sel_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(w_start) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!w_found && bus.in_valid[idx]) begin
            w_found    = 1'b1;
            w_winner   = CH_W'(idx);
            w_sel_data = bus.in_data[idx*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_in_ready = '0;
      if (w_xfer) w_in_ready[w_winner] = 1'b1;
   end

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
   assign w_start = '0;
`else
   generate
      if (N_CH > 1) begin : g_ptr
         logic [CH_W-1:0] r_ptr;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_ptr <= '0;
            else if (w_xfer)
               r_ptr <= (w_winner == CH_W'(N_CH-1)) ? '0 : w_winner + 1'b1;
         end
         assign w_start = r_ptr;
      end else begin : g_no_ptr
         assign w_start = '0;
      end
   endgenerate
`endif

   // A load takes priority over a drain so a word can enter as another leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ch    <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_sel_data;
         r_ch    <= w_winner;
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_ch    = r_ch;
endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
//============================================================================
// Module   : tb_rr_arb_mux
// Purpose  : Table vectors, reset sequences and random traffic vs. a queue-free
//            arbitration model for rr_arb_mux (honours RR_ARB_MUX_FIXED_PRIO_EN).
// Revision : 1.0
//============================================================================
module tb_rr_arb_mux;
   localparam int N_CH  = 4;
   localparam int WIDTH = 8;

   typedef struct {
      logic [3:0] iv;
      logic       ordy;
      logic [3:0] rdy;
      logic       ov;
      logic [7:0] od;
      logic [1:0] och;
   } vec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic mon_en;
   vec_t tbl[$];

   rr_arb_mux_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

   rr_arb_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [3:0] iv, input logic ordy, input logic [3:0] rdy,
                      input logic ov, input logic [7:0] od, input logic [1:0] och);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.od = od; v.och = och;
      tbl.push_back(v);
   endtask

   // Sender-rule monitor: a raised valid must stay high with stable data until taken.
   logic [3:0] last_iv;
   logic [3:0] last_fire;
   logic [31:0] last_dat;
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < N_CH; i++)
            if (last_iv[i] && !last_fire[i] &&
                (!bus.in_valid[i] || bus.in_data[i*8 +: 8] !== last_dat[i*8 +: 8]))
               $error("sender rule broken on channel %0d", i);
         last_iv   = bus.in_valid;
         last_fire = bus.in_valid & bus.in_ready;
         last_dat  = bus.in_data;
      end else begin
         last_iv   = '0;
         last_fire = '0;
         last_dat  = '0;
      end
   end

   localparam logic [31:0] DFLT = 32'h13121110;

   int         mptr;
   logic       mv;
   logic [7:0] md;
   logic [1:0] mc;
   logic [3:0] riv;
   logic [7:0] rdat [4];

   initial begin
      total = 0; bad = 0; mon_en = 1'b0;
      rst = 1'b1;
      bus.in_valid = '0; bus.in_data = DFLT; bus.out_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_out_data",  {24'd0, bus.out_data}, 32'd0);
      chk("reset_out_ch",    {30'd0, bus.out_ch}, 32'd0);
      rst = 1'b0;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
      add(4'b1111, 1, 4'b0001, 1, 8'h10, 2'd0);
      add(4'b1111, 1, 4'b0001, 1, 8'h10, 2'd0);
      add(4'b1111, 1, 4'b0001, 1, 8'h10, 2'd0);
      add(4'b1110, 1, 4'b0010, 1, 8'h11, 2'd1);
      add(4'b1110, 1, 4'b0010, 1, 8'h11, 2'd1);
      add(4'b1010, 1, 4'b0010, 1, 8'h11, 2'd1);
      add(4'b1000, 1, 4'b1000, 1, 8'h13, 2'd3);
      add(4'b1000, 0, 4'b0000, 1, 8'h13, 2'd3);
      add(4'b0000, 1, 4'b0000, 0, 8'h13, 2'd3);
`else
      add(4'b1111, 1, 4'b0001, 1, 8'h10, 2'd0);
      add(4'b1111, 1, 4'b0010, 1, 8'h11, 2'd1);
      add(4'b1111, 1, 4'b0100, 1, 8'h12, 2'd2);
      add(4'b1111, 1, 4'b1000, 1, 8'h13, 2'd3);
      add(4'b1111, 1, 4'b0001, 1, 8'h10, 2'd0);
      add(4'b1010, 1, 4'b0010, 1, 8'h11, 2'd1);
      add(4'b1010, 1, 4'b1000, 1, 8'h13, 2'd3);
      add(4'b1010, 1, 4'b0010, 1, 8'h11, 2'd1);
      add(4'b1111, 0, 4'b0000, 1, 8'h11, 2'd1);
      add(4'b1111, 0, 4'b0000, 1, 8'h11, 2'd1);
      add(4'b1111, 0, 4'b0000, 1, 8'h11, 2'd1);
      add(4'b1111, 0, 4'b0000, 1, 8'h11, 2'd1);
      add(4'b1111, 0, 4'b0000, 1, 8'h11, 2'd1);
      add(4'b1111, 1, 4'b0100, 1, 8'h12, 2'd2);
      add(4'b0000, 1, 4'b0000, 0, 8'h12, 2'd2);
      add(4'b0000, 1, 4'b0000, 0, 8'h12, 2'd2);
      add(4'b1111, 1, 4'b1000, 1, 8'h13, 2'd3);
      add(4'b0001, 0, 4'b0000, 1, 8'h13, 2'd3);
      add(4'b0001, 1, 4'b0001, 1, 8'h10, 2'd0);
      add(4'b0000, 0, 4'b0000, 1, 8'h10, 2'd0);
`endif

      for (int k = 0; k < tbl.size(); k++) begin
         bus.in_valid  = tbl[k].iv;
         bus.out_ready = tbl[k].ordy;
         bus.in_data   = DFLT;
         #2;
         chk($sformatf("vec%0d_in_ready", k), {28'd0, bus.in_ready}, {28'd0, tbl[k].rdy});
         @(posedge clk); #1;
         chk($sformatf("vec%0d_out_valid", k), {31'd0, bus.out_valid}, {31'd0, tbl[k].ov});
         chk($sformatf("vec%0d_out_data", k),  {24'd0, bus.out_data},  {24'd0, tbl[k].od});
         chk($sformatf("vec%0d_out_ch", k),    {30'd0, bus.out_ch},    {30'd0, tbl[k].och});
      end

      // Asynchronous reset mid-cycle while a word is held.
      bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_out_valid", {31'd0, bus.out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("async_rst_out_data",  {24'd0, bus.out_data}, 32'd0);
      chk("async_rst_out_ch",    {30'd0, bus.out_ch}, 32'd0);
      #1 rst = 1'b0;
      bus.in_valid = 4'b0100; bus.in_data = 32'h1BA5_1910; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("post_rst_out_data",  {24'd0, bus.out_data}, 32'h0000_00A5);
      chk("post_rst_out_ch",    {30'd0, bus.out_ch}, 32'd2);

      // Pointer must restart at 0 after reset.
      bus.in_valid = 4'b0000;
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      bus.in_valid = 4'b1111; bus.in_data = DFLT;
      @(posedge clk); #1;
      chk("rst_ptr_out_ch",   {30'd0, bus.out_ch}, 32'd0);
      chk("rst_ptr_out_data", {24'd0, bus.out_data}, 32'h10);

      // Random traffic against the arbitration model.
      bus.in_valid = '0; bus.out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mptr = 0; mv = 1'b0; md = '0; mc = '0; riv = '0;
      for (int i = 0; i < N_CH; i++) rdat[i] = '0;
      mon_en = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         int         start;
         int         win;
         logic       ordy;
         logic [3:0] exp_rdy;
         for (int i = 0; i < N_CH; i++)
            if (!riv[i] && $urandom_range(0, 2) == 0) begin
               riv[i]  = 1'b1;
               rdat[i] = 8'($urandom);
            end
         ordy = ($urandom_range(0, 3) != 0);
         bus.in_valid  = riv;
         bus.out_ready = ordy;
         for (int i = 0; i < N_CH; i++) bus.in_data[i*8 +: 8] = rdat[i];
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
         start = 0;
`else
         start = mptr;
`endif
         win = -1;
         for (int k = 0; k < N_CH; k++)
            if (win < 0 && riv[(start + k) % N_CH]) win = (start + k) % N_CH;
         exp_rdy = '0;
         if ((!mv || ordy) && win >= 0) exp_rdy[win] = 1'b1;
         #2;
         chk("rand_in_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
         @(posedge clk);
         if (exp_rdy != 4'b0000) begin
            mv = 1'b1; md = rdat[win]; mc = 2'(win);
            mptr = (win + 1) % N_CH;
            riv[win] = 1'b0;
         end else if (ordy) begin
            mv = 1'b0;
         end
         #1;
         chk("rand_out_valid", {31'd0, bus.out_valid}, {31'd0, mv});
         chk("rand_out_data",  {24'd0, bus.out_data},  {24'd0, md});
         chk("rand_out_ch",    {30'd0, bus.out_ch},    {30'd0, mc});
      end
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
